// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
    localparam logic RAM_READ  = 1'b1;
    localparam logic RAM_WRITE = 1'b0;
    localparam int AW_DEF = 9;
    localparam int DW_DEF = 16;
endpackage

// File: rtl/fetch_pc_reg.sv
// pc_reg: program counter with load-over-increment priority and natural wrap
module pc_reg #(
    parameter int AW = 9,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          inc,
    output logic [AW-1:0] pc
);
    always_ff @(posedge clk)
        if (!rst_n) pc <= RESET_PC;
        else if (load) pc <= load_val;
        else if (inc) pc <= pc + 1'b1;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven RAM fetch with registered instruction output and valid/ready handoff
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          redirect,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    input  logic [DW-1:0] ram_rdata,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [15:0]   fetch_count
);
    state_t state, next;
    logic capture, hs;
    assign ram_we = RAM_READ;
    assign hs = instr_valid & instr_ready;
    pc_reg #(.AW(AW), .RESET_PC(RESET_PC)) u_pc (
        .clk(clk),
        .rst_n(rst_n),
        .load(redirect),
        .load_val(target),
        .inc(capture),
        .pc(ram_addr)
    );
    always_ff @(posedge clk)
        if (!rst_n) state <= IDLE;
        else state <= next;
    // redirect outranks capture; the handshake counts even when redirected
    always_comb begin
        capture = state == WAIT && !redirect;
        next = state == IDLE  ? (en ? ISSUE : IDLE) :
               redirect       ? ISSUE :
               state == ISSUE ? WAIT :
               state == WAIT  ? HOLD :
               hs             ? (en ? WAIT : IDLE) : HOLD;
    end
    always_ff @(posedge clk)
        if (!rst_n) begin
            instr <= '0;
            instr_pc <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (capture) begin
                instr <= ram_rdata;
                instr_pc <= ram_addr;
            end
            instr_valid <= capture | (instr_valid & ~hs & ~redirect);
            if (hs) fetch_count <= fetch_count + 1'b1;
        end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a per-cycle transaction-level monitor
module tb_fetch_unit;
    typedef struct {logic [15:0] d; logic [8:0] p;} word_t;
    logic clk = 0, rst_n = 0, en = 0, redirect = 0, instr_ready = 0;
    logic [8:0] target = '0, ram_addr, instr_pc;
    logic ram_we, instr_valid;
    logic [15:0] ram_rdata, instr, fetch_count;
    logic [15:0] mem [512];
    int checks = 0, errors = 0, cyc = 0, n;
    bit started = 0;
    word_t acc_q[$];
    int hs_cyc[$];
    logic [15:0] exp_count, prev_i;
    logic [8:0] exp_pc, prev_p;
    logic prev_v = 0, last_rst = 0, last_redir = 0;

    fetch_unit #(.AW(9), .DW(16), .RESET_PC(9'd0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .redirect(redirect), .target(target),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_rdata <= mem[ram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // transaction model: counts handshakes, tracks where the next word must come from
    always @(posedge clk) begin
        cyc++;
        last_rst = !rst_n;
        last_redir = rst_n && redirect;
        if (rst_n && instr_valid && instr_ready) begin
            exp_count++;
            acc_q.push_back('{instr, instr_pc});
            hs_cyc.push_back(cyc);
        end
        if (!rst_n) begin
            exp_count = 0;
            exp_pc = 9'd0;
        end else if (redirect) exp_pc = target;
    end

    always @(negedge clk) if (started) begin
        chk("ram_we", ram_we, 1);
        if (last_rst) begin
            chk("rst_instr", instr, 0);
            chk("rst_instr_pc", instr_pc, 0);
            chk("rst_valid", instr_valid, 0);
        end else begin
            if (last_redir) chk("redirect_drop", instr_valid, 0);
            if (instr_valid && !prev_v) begin
                chk("word_pc", instr_pc, exp_pc);
                chk("word_data", instr, mem[exp_pc]);
                exp_pc = exp_pc + 1'b1;
            end else if (instr_valid && prev_v) begin
                chk("hold_instr", instr, prev_i);
                chk("hold_pc", instr_pc, prev_p);
            end
        end
        chk("fetch_count", fetch_count, exp_count);
        chk("ram_addr", ram_addr, exp_pc);
        prev_v = instr_valid;
        prev_i = instr;
        prev_p = instr_pc;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic restart;
        en = 0;
        instr_ready = 0;
        redirect = 0;
        acc_q.delete();
        hs_cyc.delete();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        started = 1;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!instr_valid && k < 50) begin
            tick();
            k++;
        end
        chk("valid_timeout", instr_valid, 1);
    endtask

    task automatic wait_acc(input int want);
        int k = 0;
        while (acc_q.size() < want && k < 100) begin
            tick();
            k++;
        end
        chk("accept_timeout", acc_q.size() >= want, 1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'(i + 1000);
        mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40; mem[511] = 77;

        // streaming with ready tied high
        restart();
        en = 1;
        instr_ready = 1;
        wait_valid(n);
        chk("first_latency", n, 3);
        wait_acc(4);
        chk("stream_count", fetch_count, 4);
        if (acc_q.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("stream_data", acc_q[i].d, 10 * (i + 1));
                chk("stream_pc", acc_q[i].p, i);
            end
            for (int i = 0; i < 3; i++) chk("stream_gap", hs_cyc[i+1] - hs_cyc[i], 2);
        end

        // backpressure holds the word
        restart();
        en = 1;
        wait_valid(n);
        repeat (5) tick();
        chk("bp_instr", instr, 10);
        chk("bp_pc", instr_pc, 0);
        chk("bp_valid", instr_valid, 1);
        chk("bp_count0", fetch_count, 0);
        instr_ready = 1;
        tick();
        instr_ready = 0;
        chk("bp_count1", fetch_count, 1);
        wait_valid(n);
        chk("bp_next_instr", instr, 20);
        chk("bp_next_pc", instr_pc, 1);

        // redirect while holding, then redirect coinciding with a handshake
        restart();
        en = 1;
        wait_valid(n);
        redirect = 1;
        target = 9'd3;
        tick();
        redirect = 0;
        chk("rd_valid", instr_valid, 0);
        chk("rd_count", fetch_count, 0);
        wait_valid(n);
        chk("rd_latency", n, 2);
        chk("rd_instr", instr, 40);
        chk("rd_pc", instr_pc, 3);
        instr_ready = 1;
        redirect = 1;
        target = 9'd0;
        tick();
        redirect = 0;
        instr_ready = 0;
        chk("rd_hs_count", fetch_count, 1);
        chk("rd_hs_valid", instr_valid, 0);
        wait_valid(n);
        chk("rd_hs_instr", instr, 10);
        chk("rd_hs_pc", instr_pc, 0);

        // wrap from 511 to 0, redirect issued from idle
        restart();
        en = 1;
        instr_ready = 1;
        redirect = 1;
        target = 9'd511;
        tick();
        redirect = 0;
        wait_acc(2);
        if (acc_q.size() >= 2) begin
            chk("wrap_d0", acc_q[0].d, 77);
            chk("wrap_p0", acc_q[0].p, 511);
            chk("wrap_d1", acc_q[1].d, 10);
            chk("wrap_p1", acc_q[1].p, 0);
        end

        // disabling during hold still delivers the word, then idles
        restart();
        en = 1;
        wait_valid(n);
        en = 0;
        repeat (3) tick();
        chk("en_held", instr_valid, 1);
        instr_ready = 1;
        tick();
        chk("en_count", fetch_count, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("en_idle_valid", instr_valid, 0);
        end
        chk("en_idle_pc", ram_addr, 1);

        // reset while holding a word
        restart();
        en = 1;
        wait_valid(n);
        instr_ready = 1;
        tick();
        instr_ready = 0;
        wait_valid(n);
        chk("pre_rst_count", fetch_count, 1);
        rst_n = 0;
        tick();
        chk("rst_mid_valid", instr_valid, 0);
        chk("rst_mid_instr", instr, 0);
        chk("rst_mid_pc", instr_pc, 0);
        chk("rst_mid_count", fetch_count, 0);
        chk("rst_mid_addr", ram_addr, 0);
        chk("rst_mid_we", ram_we, 1);
        rst_n = 1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the 512×16 single-port RAM in the PC/RAM datapath. It owns the program counter, drives the RAM address and write-enable, captures the RAM's read data into an instruction register, and hands each fetched word downstream over a valid/ready handshake. It supports redirect (jump) at any time and an enable gate for start/stop.

## Interface
- `AW`, 9, RAM address width and PC width
- `DW`, 16, RAM data and instruction width
- `RESET_PC`, 9'd0, PC value loaded on reset
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `en`  in  1  1 = fetch enabled; 0 = finish current word, then idle
- `redirect`  in  1  load PC from `target` this cycle
- `target`  in  AW  redirect address
- `ram_addr`  out  AW  RAM address; always equal to PC register
- `ram_we`  out  1  RAM mode; held 1'b1 (read; RAM writes when 0)
- `ram_rdata`  in  DW  RAM output; registered, valid the cycle after the address has been stable for one edge
- `instr`  out  DW  fetched word
- `instr_pc`  out  AW  address `instr` came from
- `instr_valid`  out  1  `instr` / `instr_pc` valid
- `instr_ready`  in  1  downstream accepts when `instr_valid & instr_ready`
- `fetch_count`  out  16  number of words accepted downstream; wraps at 2^16

## Operation
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: `instr_valid`=0; if `en`=1, go to ISSUE.
- ISSUE: PC is presented on `ram_addr`; the RAM latches it at this edge. Go to WAIT.
- WAIT: `ram_rdata` = mem[PC]. At the edge: `instr` ← `ram_rdata`, `instr_pc` ← PC, `instr_valid` ← 1, PC ← PC+1 (mod 2^AW; 511 wraps to 0). Go to HOLD.
- HOLD: outputs are held stable while `instr_ready`=0. On handshake: `instr_valid` ← 0, `fetch_count` += 1. Then go to WAIT if `en`=1, else IDLE. The new PC has already been stable for at least one edge, so WAIT captures valid data.
- Redirect in ISSUE, WAIT or HOLD: PC ← `target`, `instr_valid` ← 0, go to ISSUE. Redirect has priority over capture.
- A handshake in the same cycle as a redirect still increments `fetch_count`; that word counts as consumed.
- Redirect in IDLE: PC ← `target`; remain in IDLE, or go to ISSUE if `en`=1.
- `en` is sampled only in IDLE and at the HOLD handshake. Deasserting `en` never drops a held word.

## Timing
- Reset values: state IDLE, PC=`RESET_PC`, `instr`=0, `instr_pc`=0, `instr_valid`=0, `fetch_count`=0.
- `ram_we`=1 in every state, including during reset.
- Reset asserted mid-fetch: all registers take reset values at that edge. Any held word is discarded without counting.
- First fetch latency: `en` sampled high in IDLE at edge E0. ISSUE runs in cycle E0–E1, WAIT in E1–E2, and `instr_valid` rises after E2.
- Sustained throughput with `instr_ready` tied to 1: one word every 2 cycles (HOLD, then WAIT).
- Redirect latency: `instr_valid` drops at the redirect edge. The word from `target` is valid 2 edges later.
- No combinational path from `instr_ready` or `redirect` to any output. `ram_addr` is a direct register output.

## Structure
- Package `fetch_pkg`:
  - state enum {IDLE, ISSUE, WAIT, HOLD}
  - constants `RAM_READ` = 1'b1 and `RAM_WRITE` = 1'b0
  - default widths AW=9, DW=16
- Sub-module `pc_reg`: AW-bit register with synchronous active-low reset to `RESET_PC`. Inputs are `load`/`load_val` and `inc`; `load` has priority over `inc`, and increment wraps.
- FSM, instruction register and counter live in `fetch_unit`.

## Test plan
All scenarios use a RAM model preloaded with mem[0..3] = 10, 20, 30, 40; tests overwrite other locations as noted.
- Reset, then `en`=1, `instr_ready`=1 → words (10,pc0), (20,pc1), (30,pc2), (40,pc3) delivered every 2 cycles. `fetch_count`=4. `ram_we` stays 1 throughout.
- `instr_ready`=0 for 5 cycles after first valid → `instr`=10 and `instr_pc`=0 held stable. Raising ready → `fetch_count`=1, and the next word is 20.
- Redirect to 3 while holding word 10 → `instr_valid` drops immediately; next word is (40, pc3). `fetch_count` unchanged if no handshake occurred.
- With mem[511]=77 and mem[0]=10, redirect to 511 → words (77,pc511), then (10,pc0) (wrap).
- `en`=0 during HOLD → held word is still delivered, then FSM returns to IDLE and `instr_valid` stays 0.
- `rst_n`=0 while in HOLD → next cycle all outputs are at reset values and PC=`RESET_PC`.
